// File: rtl/sliced_oai_pkg.sv
// Shared constants and per-group bit functions for the sliced INV/OAI222 pipeline.
package sliced_oai_pkg;

  localparam int GROUP_W = 4;

  function automatic logic [GROUP_W-1:0] oai_group(input logic [GROUP_W-1:0] a4,
                                                   input logic [GROUP_W-1:0] b4);
    logic [GROUP_W-1:0] c4;
    c4[0] = ~a4[0];
    c4[1] = ~b4[0];
    c4[2] = ~b4[1];
    c4[3] = ~((a4[1] | a4[2]) & (b4[1] | b4[2]) & (a4[3] | b4[3]));
    return c4;
  endfunction

  function automatic logic [GROUP_W-1:0] bypass_group(input logic [GROUP_W-1:0] a4,
                                                      input logic [GROUP_W-1:0] b4);
    return a4 ^ b4;
  endfunction

endpackage

// File: rtl/sliced_oai_lane.sv
// One combinational lane: INV/OAI222 per 4-bit group, XOR in bypass, zero when disabled.
module sliced_oai_lane
  import sliced_oai_pkg::*;
#(
  parameter int SLICE_W = 12
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               en,
  input  logic               bypass,
  output logic [SLICE_W-1:0] c
);

  always_comb begin
    c = '0;
    if (en) begin
      for (int g = 0; g < SLICE_W / GROUP_W; g++) begin
        if (bypass)
          c[g*GROUP_W +: GROUP_W] = bypass_group(a[g*GROUP_W +: GROUP_W], b[g*GROUP_W +: GROUP_W]);
        else
          c[g*GROUP_W +: GROUP_W] = oai_group(a[g*GROUP_W +: GROUP_W], b[g*GROUP_W +: GROUP_W]);
      end
    end
  end

endmodule

// File: rtl/sliced_oai_pipe.sv
// Two-stage valid/ready pipeline around NUM_SLICES sliced_oai_lane instances,
// with an output-handshake counter.
module sliced_oai_pipe
  import sliced_oai_pkg::*;
#(
  parameter int NUM_SLICES = 3,
  parameter int SLICE_W    = 12,
  parameter int BUS_W      = 41,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BUS_W-1:0]      in_a,
  input  logic [BUS_W-1:0]      in_b,
  input  logic [NUM_SLICES-1:0] in_slice_en,
  input  logic                  in_bypass,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BUS_W-1:0]      out_c,
  output logic [CNT_W-1:0]      xfer_cnt
);

  localparam int LANE_BITS = NUM_SLICES * SLICE_W;

  if (SLICE_W % GROUP_W != 0) begin : g_bad_slice_w
    $error("SLICE_W must be a multiple of 4");
  end
  if (BUS_W < LANE_BITS) begin : g_bad_bus_w
    $error("BUS_W must be >= NUM_SLICES*SLICE_W");
  end

  logic                  s1_valid, s2_valid;
  logic [LANE_BITS-1:0]  s1_a, s1_b, s2_c, c_lanes;
  logic [NUM_SLICES-1:0] s1_en;
  logic                  s1_bypass;
  logic [CNT_W-1:0]      cnt_q;
  logic                  s1_adv, s2_adv;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  for (genvar i = 0; i < NUM_SLICES; i++) begin : g_lane
    sliced_oai_lane #(.SLICE_W(SLICE_W)) u_lane (
      .a      (s1_a[i*SLICE_W +: SLICE_W]),
      .b      (s1_b[i*SLICE_W +: SLICE_W]),
      .en     (s1_en[i]),
      .bypass (s1_bypass),
      .c      (c_lanes[i*SLICE_W +: SLICE_W])
    );
  end

  // Spare operand bits never reach the result.
  if (BUS_W > LANE_BITS) begin : g_spare
    logic unused_spare;
    assign unused_spare = ^{in_a[BUS_W-1:LANE_BITS], in_b[BUS_W-1:LANE_BITS]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_en     <= '0;
      s1_bypass <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a      <= in_a[LANE_BITS-1:0];
        s1_b      <= in_b[LANE_BITS-1:0];
        s1_en     <= in_slice_en;
        s1_bypass <= in_bypass;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_c     <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_c <= c_lanes;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else if (s2_valid && out_ready)
      cnt_q <= cnt_q + CNT_W'(1);
  end

  assign out_valid = s2_valid;
  assign out_c     = BUS_W'(s2_c);
  assign xfer_cnt  = cnt_q;

endmodule
